uart_packet_parser: RTL and testbench
=====================================

UART_PACKET_PARSER -- requirements
Module: uart_packet_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-002 Parameter TIMEOUT_CLKS, default 1000000: maximum idle clocks between bytes inside a frame (10 ms at 100 MHz).
REQ-003 clock  input  1  100 MHz system clock; all logic SHALL be rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received byte from the UART receiver; valid only while rx_ready=1.
REQ-006 rx_ready  input  1  single-cycle new-byte strobe from the UART receiver.
REQ-007 pkt_valid  output  1  one-cycle pulse: a good frame has been decoded.
REQ-008 pkt_type  output  8  frame type byte, registered.
REQ-009 pkt_x  output  8  frame X byte, registered.
REQ-010 pkt_y  output  8  frame Y byte, registered.
REQ-011 err_pulse  output  1  one-cycle pulse on checksum error or timeout.
REQ-012 err_count  output  8  saturating count of errors.
REQ-013 busy  output  1  high while in any state other than WAIT_SYNC.

Function
REQ-014 Frame format: SYNC_BYTE, TYPE, X, Y, CSUM, where CSUM = TYPE ^ X ^ Y (8-bit XOR).
REQ-015 The FSM SHALL have the states WAIT_SYNC, GET_TYPE, GET_X, GET_Y and GET_CSUM.
REQ-016 The FSM SHALL advance one state per accepted byte (rx_ready=1); it SHALL NOT sample rx_data when rx_ready=0.
REQ-017 WAIT_SYNC: rx_data==SYNC_BYTE -> GET_TYPE; any other byte is silently discarded (no error).
REQ-018 GET_TYPE, GET_X and GET_Y SHALL capture the byte into internal holding registers; a SYNC_BYTE value in these states is payload, not a resync.
REQ-019 GET_CSUM with matching checksum: the FSM SHALL load pkt_type, pkt_x and pkt_y from the holding registers and assert pkt_valid for exactly one cycle, on the edge that samples the CSUM strobe, then go to WAIT_SYNC.
REQ-020 GET_CSUM with mismatching checksum: pkt_* SHALL be unchanged, err_pulse SHALL be asserted for one cycle, and the FSM SHALL go to WAIT_SYNC.
REQ-021 pkt_type, pkt_x and pkt_y SHALL hold their last good values until the next good frame.
REQ-022 Timeout counter: cleared on every accepted byte and in WAIT_SYNC; incremented each cycle in the other states.
REQ-023 Timeout: when the counter reaches TIMEOUT_CLKS-1 with no rx_ready, err_pulse SHALL be asserted for one cycle and the FSM SHALL go to WAIT_SYNC; that partial frame is discarded.
REQ-024 If rx_ready coincides with the timeout cycle, the byte SHALL win: it is processed normally and no timeout is raised.
REQ-025 err_count SHALL increment by 1 on every err_pulse and saturate at 8'hFF (no wrap).
REQ-026 pkt_valid and err_pulse SHALL never be asserted in the same cycle.
REQ-027 Latency from the CSUM rx_ready to pkt_valid SHALL be 1 clock.
REQ-028 The block SHALL accept back-to-back strobes one cycle apart, with no lost bytes.

Reset
REQ-029 On reset low, asynchronously: state=WAIT_SYNC; pkt_valid=0; err_pulse=0; busy=0; pkt_type, pkt_x, pkt_y=8'h00; err_count=8'h00; holding registers and timeout counter=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits for a fresh SYNC_BYTE.
REQ-031 The first clock after reset release SHALL process rx_ready normally.

Verification
REQ-032 Bytes A5,01,10,20,31 -> one pkt_valid pulse; pkt_type=01, pkt_x=10, pkt_y=20; err_count=0.
REQ-033 Bytes A5,01,10,20,00 -> err_pulse once, err_count=1, pkt_* unchanged, busy=0 afterwards.
REQ-034 Bytes 00,FF,A5,02,A5,A5,02 (CSUM = 02^A5^A5) -> leading 00,FF ignored; pkt_valid with type=02, x=A5, y=A5.
REQ-035 TIMEOUT_CLKS=100; bytes A5,01 then idle for 150 clocks -> err_pulse exactly 100 clocks after the 01 strobe; then A5,03,00,00,03 -> pkt_valid, type=03.
REQ-036 Force 300 bad-checksum frames -> err_count saturates at FF.
REQ-037 Reset asserted after A5,01,10 -> all outputs zero; then 20,31 ignored, no pkt_valid; then a full valid frame decodes correctly.

Source files
------------

// File: rtl/uart_packet_parser.sv
// Decodes SYNC/TYPE/X/Y/CSUM frames from a UART byte stream.
// Checksum failures and inter-byte timeouts are flagged and counted.
module uart_packet_parser #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       pkt_valid,
   output logic [7:0] pkt_type,
   output logic [7:0] pkt_x,
   output logic [7:0] pkt_y,
   output logic       err_pulse,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam int unsigned CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      WAIT_SYNC,
      GET_TYPE,
      GET_X,
      GET_Y,
      GET_CSUM
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       type_h_q, type_h_d;
   logic [7:0]       x_h_q, x_h_d;
   logic [7:0]       y_h_q, y_h_d;
   logic [7:0]       pkt_type_q, pkt_type_d;
   logic [7:0]       pkt_x_q, pkt_x_d;
   logic [7:0]       pkt_y_q, pkt_y_d;
   logic             pkt_valid_q, pkt_valid_d;
   logic             err_pulse_q, err_pulse_d;
   logic [7:0]       err_count_q, err_count_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   logic             csum_ok;
   logic             timeout;

   assign csum_ok = (rx_data == (type_h_q ^ x_h_q ^ y_h_q));
   // An arriving byte always beats the timeout on the same cycle.
   assign timeout = (state_q != WAIT_SYNC) && !rx_ready && (tmo_cnt_q == TMO_LAST);

   // State register and all datapath flops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= WAIT_SYNC;
         type_h_q    <= '0;
         x_h_q       <= '0;
         y_h_q       <= '0;
         pkt_type_q  <= '0;
         pkt_x_q     <= '0;
         pkt_y_q     <= '0;
         pkt_valid_q <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         type_h_q    <= type_h_d;
         x_h_q       <= x_h_d;
         y_h_q       <= y_h_d;
         pkt_type_q  <= pkt_type_d;
         pkt_x_q     <= pkt_x_d;
         pkt_y_q     <= pkt_y_d;
         pkt_valid_q <= pkt_valid_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (rx_ready) begin
         case (state_q)
            WAIT_SYNC: if (rx_data == SYNC_BYTE) state_d = GET_TYPE;
            GET_TYPE:  state_d = GET_X;
            GET_X:     state_d = GET_Y;
            GET_Y:     state_d = GET_CSUM;
            GET_CSUM:  state_d = WAIT_SYNC;
            default:   state_d = WAIT_SYNC;
         endcase
      end else if (timeout) begin
         state_d = WAIT_SYNC;
      end
   end

   // Output and datapath logic
   always_comb begin
      type_h_d    = type_h_q;
      x_h_d       = x_h_q;
      y_h_d       = y_h_q;
      pkt_type_d  = pkt_type_q;
      pkt_x_d     = pkt_x_q;
      pkt_y_d     = pkt_y_q;
      pkt_valid_d = 1'b0;
      err_pulse_d = 1'b0;
      tmo_cnt_d   = (state_q == WAIT_SYNC) ? '0 : tmo_cnt_q + CNT_W'(1);

      if (rx_ready) begin
         tmo_cnt_d = '0;
         case (state_q)
            GET_TYPE: type_h_d = rx_data;
            GET_X:    x_h_d    = rx_data;
            GET_Y:    y_h_d    = rx_data;
            GET_CSUM: begin
               if (csum_ok) begin
                  pkt_type_d  = type_h_q;
                  pkt_x_d     = x_h_q;
                  pkt_y_d     = y_h_q;
                  pkt_valid_d = 1'b1;
               end else begin
                  err_pulse_d = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (timeout) begin
         tmo_cnt_d   = '0;
         err_pulse_d = 1'b1;
      end

      err_count_d = err_count_q;
      if (err_pulse_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
   end

   assign pkt_valid = pkt_valid_q;
   assign pkt_type  = pkt_type_q;
   assign pkt_x     = pkt_x_q;
   assign pkt_y     = pkt_y_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign busy      = (state_q != WAIT_SYNC);

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed bench for uart_packet_parser: frame vectors plus timeout,
// saturation and reset sequences, with a short inter-byte timeout.
module tb_uart_packet_parser;

   localparam int unsigned TMO = 100;

   logic       clock;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       pkt_valid;
   logic [7:0] pkt_type;
   logic [7:0] pkt_x;
   logic [7:0] pkt_y;
   logic       err_pulse;
   logic [7:0] err_count;
   logic       busy;

   uart_packet_parser #(
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .pkt_valid(pkt_valid),
      .pkt_type (pkt_type),
      .pkt_x    (pkt_x),
      .pkt_y    (pkt_y),
      .err_pulse(err_pulse),
      .err_count(err_count),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Pulse counters, written only here and read away from the negedge
   int valid_total = 0;
   int err_total   = 0;
   int overlap     = 0;
   always @(negedge clock) begin
      if (pkt_valid) valid_total <= valid_total + 1;
      if (err_pulse) err_total <= err_total + 1;
      if (pkt_valid && err_pulse) overlap <= overlap + 1;
   end

   typedef struct {
      logic [55:0] bytes;   // first byte in bits 55:48
      int          n;
      int          exp_valid;
      int          exp_err;
      logic [7:0]  exp_type;
      logic [7:0]  exp_x;
      logic [7:0]  exp_y;
      logic [7:0]  exp_ecnt;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bytes(input logic [55:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         rx_ready = 1'b1;
         rx_data  = b[55-8*i -: 8];
      end
      @(negedge clock);
      rx_ready = 1'b0;
      rx_data  = '0;
   endtask

   task automatic settle();
      repeat (3) @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0, e0, o0, first, pulses;

      vecs[0] = '{{8'hA5, 8'h01, 8'h10, 8'h20, 8'h31, 16'h0}, 5, 1, 0, 8'h01, 8'h10, 8'h20, 8'h00};
      vecs[1] = '{{8'hA5, 8'h01, 8'h10, 8'h20, 8'h00, 16'h0}, 5, 0, 1, 8'h01, 8'h10, 8'h20, 8'h01};
      vecs[2] = '{{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02}, 7, 1, 0, 8'h02, 8'hA5, 8'hA5, 8'h01};
      vecs[3] = '{{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 16'h0}, 5, 1, 0, 8'hA5, 8'hA5, 8'hA5, 8'h01};
      vecs[4] = '{{8'hA5, 8'hFF, 8'h00, 8'h0F, 8'hF0, 16'h0}, 5, 1, 0, 8'hFF, 8'h00, 8'h0F, 8'h01};
      vecs[5] = '{{8'h12, 8'h34, 40'h0}, 2, 0, 0, 8'hFF, 8'h00, 8'h0F, 8'h01};

      reset    = 1'b0;
      rx_ready = 1'b0;
      rx_data  = '0;
      repeat (2) @(negedge clock);
      check("rst_valid", 32'(pkt_valid), 0);
      check("rst_err", 32'(err_pulse), 0);
      check("rst_type", 32'(pkt_type), 0);
      check("rst_x", 32'(pkt_x), 0);
      check("rst_y", 32'(pkt_y), 0);
      check("rst_ecnt", 32'(err_count), 0);
      check("rst_busy", 32'(busy), 0);
      reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         v0 = valid_total; e0 = err_total; o0 = overlap;
         send_bytes(vecs[i].bytes, vecs[i].n);
         settle();
         check($sformatf("vec%0d_valid", i), 32'(valid_total - v0), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_err", i), 32'(err_total - e0), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_type", i), 32'(pkt_type), 32'(vecs[i].exp_type));
         check($sformatf("vec%0d_x", i), 32'(pkt_x), 32'(vecs[i].exp_x));
         check($sformatf("vec%0d_y", i), 32'(pkt_y), 32'(vecs[i].exp_y));
         check($sformatf("vec%0d_ecnt", i), 32'(err_count), 32'(vecs[i].exp_ecnt));
         check($sformatf("vec%0d_busy", i), 32'(busy), 0);
         check($sformatf("vec%0d_overlap", i), 32'(overlap - o0), 0);
      end

      // One-clock latency from the CSUM strobe, pulse lasts one cycle
      send_bytes({8'hA5, 8'h03, 8'h00, 8'h00, 24'h0}, 4);
      @(negedge clock);
      rx_ready = 1'b1; rx_data = 8'h03;
      @(posedge clock); #1;
      rx_ready = 1'b0;
      check("lat_valid", 32'(pkt_valid), 1);
      check("lat_type", 32'(pkt_type), 8'h03);
      @(posedge clock); #1;
      check("lat_valid_drop", 32'(pkt_valid), 0);

      // Timeout: err_pulse exactly TMO clocks after the last strobe
      @(negedge clock);
      rx_ready = 1'b1; rx_data = 8'hA5;
      @(negedge clock);
      rx_data = 8'h01;
      @(posedge clock); #1;
      rx_ready = 1'b0;
      first = 0; pulses = 0;
      for (int k = 1; k <= 150; k++) begin
         @(posedge clock); #1;
         if (err_pulse) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      check("tmo_delay", 32'(first), 32'(TMO));
      check("tmo_pulses", 32'(pulses), 1);
      check("tmo_ecnt", 32'(err_count), 8'h02);
      check("tmo_busy", 32'(busy), 0);
      v0 = valid_total;
      send_bytes({8'hA5, 8'h03, 8'h00, 8'h00, 8'h03, 16'h0}, 5);
      settle();
      check("tmo_next_valid", 32'(valid_total - v0), 1);
      check("tmo_next_type", 32'(pkt_type), 8'h03);

      // A byte on the timeout cycle is taken and suppresses the timeout
      v0 = valid_total; e0 = err_total;
      @(negedge clock);
      rx_ready = 1'b1; rx_data = 8'hA5;
      @(negedge clock);
      rx_data = 8'h01;
      @(posedge clock); #1;
      rx_ready = 1'b0;
      repeat (TMO - 1) @(posedge clock);
      #1;
      rx_ready = 1'b1; rx_data = 8'h10;
      @(posedge clock); #1;
      rx_ready = 1'b0;
      check("win_err", 32'(err_pulse), 0);
      check("win_busy", 32'(busy), 1);
      send_bytes({8'h20, 8'h31, 40'h0}, 2);
      settle();
      check("win_valid", 32'(valid_total - v0), 1);
      check("win_errs", 32'(err_total - e0), 0);
      check("win_type", 32'(pkt_type), 8'h01);
      check("win_x", 32'(pkt_x), 8'h10);
      check("win_y", 32'(pkt_y), 8'h20);
      check("win_ecnt", 32'(err_count), 8'h02);

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         send_bytes({8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 16'h0}, 5);
         if (i == 251) begin
            @(posedge clock); #1;
            check("sat_fe", 32'(err_count), 8'hFE);
         end
      end
      settle();
      check("sat_ff", 32'(err_count), 8'hFF);
      check("sat_type", 32'(pkt_type), 8'h01);
      check("sat_busy", 32'(busy), 0);

      // Reset mid-frame
      send_bytes({8'hA5, 8'h01, 8'h10, 32'h0}, 3);
      #2;
      reset = 1'b0;
      #1;
      check("mrst_type", 32'(pkt_type), 0);
      check("mrst_x", 32'(pkt_x), 0);
      check("mrst_y", 32'(pkt_y), 0);
      check("mrst_ecnt", 32'(err_count), 0);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_valid", 32'(pkt_valid), 0);
      check("mrst_err", 32'(err_pulse), 0);
      @(negedge clock);
      reset = 1'b1;
      v0 = valid_total; e0 = err_total;
      send_bytes({8'h20, 8'h31, 40'h0}, 2);
      settle();
      check("mrst_tail_valid", 32'(valid_total - v0), 0);
      check("mrst_tail_err", 32'(err_total - e0), 0);
      check("mrst_tail_busy", 32'(busy), 0);

      // Byte presented on the first clock after reset release
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      rx_ready = 1'b1; rx_data = 8'hA5;
      v0 = valid_total;
      send_bytes({8'h07, 8'h08, 8'h09, 8'h06, 24'h0}, 4);
      settle();
      check("post_valid", 32'(valid_total - v0), 1);
      check("post_type", 32'(pkt_type), 8'h07);
      check("post_x", 32'(pkt_x), 8'h08);
      check("post_y", 32'(pkt_y), 8'h09);
      check("post_overlap", 32'(overlap), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
